stream_fork_dynamic: RTL and testbench

// - Splits one valid/ready stream into N_OUP output streams. sel_i chooses, per beat, which outputs receive it.
// - The input beat completes only after every selected output has handshaked. Outputs may accept in any cycles.
// - Payload is not stored here: data is wired from the source to all sinks outside this block.
// - Sits upstream of multiple consumers, e.g. AXI-to-mem request fan-out. Dual of the dynamic stream join.

---
 rtl/stream_fork_dynamic.sv | 74 +++++++
 tb/tb_stream_fork_dynamic.sv | 167 ++++++++++++++++
 2 files changed

// File: rtl/stream_fork_dynamic.sv
// Dynamic stream fork: one valid/ready beat is delivered to every output selected by sel_i.
// Optional macro STREAM_FORK_DYNAMIC_SEL_LOCK_EN freezes the destination mask once a beat is partially delivered.
module stream_fork_dynamic #(
  parameter int unsigned N_OUP = 2
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             valid_i,
  output logic             ready_o,
  input  logic [N_OUP-1:0] sel_i,
  output logic [N_OUP-1:0] valid_o,
  input  logic [N_OUP-1:0] ready_i,
  output logic             busy_o
);

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_PARTIAL = 1'b1
  } state_e;

  state_e           w_state;
  logic [N_OUP-1:0] r_sent;
  logic [N_OUP-1:0] w_sent_next;
  logic [N_OUP-1:0] w_sel_eff;
  logic [N_OUP-1:0] w_hs;
  logic [N_OUP-1:0] w_done;

  // The beat's progress lives entirely in r_sent; any delivered output means PARTIAL.
  assign w_state = (|r_sent) ? ST_PARTIAL : ST_IDLE;

`ifdef STREAM_FORK_DYNAMIC_SEL_LOCK_EN
  logic [N_OUP-1:0] r_sel;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sel <= '0;
    end else if (w_state == ST_IDLE && valid_i) begin
      r_sel <= sel_i;
    end
  end

  assign w_sel_eff = (w_state == ST_PARTIAL) ? r_sel : sel_i;
`else
  assign w_sel_eff = sel_i;
`endif

  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
    valid_o = '0;
    ready_o = 1'b0;
    w_hs    = '0;
    w_done  = '0;
    // Outputs are forced quiet while reset is asserted, even though valid_i may be high.
    if (rst_ni) begin
      valid_o = {N_OUP{valid_i}} & w_sel_eff & ~r_sent;
      w_hs    = valid_o & ready_i;
      w_done  = ~w_sel_eff | r_sent | w_hs;
      ready_o = valid_i & (|w_sel_eff) & (&w_done);
    end
    w_sent_next = ready_o ? '0 : (r_sent | w_hs);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_sent <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignment so all flops update from pre-edge values.
      r_sent <= w_sent_next;
    end
  end

  assign busy_o = (w_state == ST_PARTIAL);

endmodule

// File: tb/tb_stream_fork_dynamic.sv
// Self-checking bench for stream_fork_dynamic (N_OUP=3): directed scenarios plus a random
// protocol-compliant run, compared against a set-based model of delivered outputs.
module tb_stream_fork_dynamic;

  localparam int N = 3;

  logic         clk_i = 1'b0;
  logic         rst_ni;
  logic         valid_i;
  logic         ready_o;
  logic [N-1:0] sel_i;
  logic [N-1:0] valid_o;
  logic [N-1:0] ready_i;
  logic         busy_o;

  int checks   = 0;
  int failures = 0;

  // Model: which outputs already own the current beat, and the mask captured at beat start.
  logic [N-1:0] m_delivered = '0;
  logic [N-1:0] m_locked    = '0;
  logic         m_last_ready = 1'b0;

  stream_fork_dynamic #(.N_OUP(N)) dut (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .valid_i (valid_i),
    .ready_o (ready_o),
    .sel_i   (sel_i),
    .valid_o (valid_o),
    .ready_i (ready_i),
    .busy_o  (busy_o)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Entered at posedge+1: drive inputs, check settled outputs before the next edge, advance model.
  task automatic step(input string tag, input logic v, input logic [N-1:0] s, input logic [N-1:0] r);
    logic [N-1:0] dest;
    logic [N-1:0] owed;
    logic [N-1:0] exp_v;
    logic         exp_r;
    logic         exp_b;
    valid_i = v;
    sel_i   = s;
    ready_i = r;
    #3;
`ifdef STREAM_FORK_DYNAMIC_SEL_LOCK_EN
    dest = (m_delivered != 0) ? m_locked : s;
`else
    dest = s;
`endif
    owed  = dest & ~m_delivered;
    exp_v = v ? owed : '0;
    exp_r = v && (dest != 0) && ((owed & ~r) == 0);
    exp_b = (m_delivered != 0);
    check({tag, ".valid_o"}, 32'(valid_o), 32'(exp_v));
    check({tag, ".ready_o"}, 32'(ready_o), 32'(exp_r));
    check({tag, ".busy_o"},  32'(busy_o),  32'(exp_b));
    @(posedge clk_i);
    if (v && m_delivered == 0) m_locked = s;
    if (exp_r) m_delivered = '0;
    else       m_delivered = m_delivered | (exp_v & r);
    m_last_ready = exp_r;
    #1;
  endtask

  initial begin
    logic         cur_v;
    logic [N-1:0] cur_s;
    logic         v;
    logic [N-1:0] s;

    // Reset held with an active source: everything quiet.
    rst_ni  = 1'b0;
    valid_i = 1'b1;
    sel_i   = 3'b111;
    ready_i = 3'b000;
    #3;
    check("rst.valid_o", 32'(valid_o), 32'h0);
    check("rst.ready_o", 32'(ready_o), 32'h0);
    check("rst.busy_o",  32'(busy_o),  32'h0);
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_hold.valid_o", 32'(valid_o), 32'h0);
    rst_ni = 1'b1;
    step("release", 1'b1, 3'b111, 3'b000);
    step("release_done", 1'b1, 3'b111, 3'b111);

    // Single-cycle beat.
    step("single", 1'b1, 3'b101, 3'b111);
    step("single_after", 1'b0, 3'b000, 3'b000);

    // Staggered acceptance across three cycles.
    step("stag1", 1'b1, 3'b111, 3'b001);
    step("stag2", 1'b1, 3'b111, 3'b100);
    step("stag3", 1'b1, 3'b111, 3'b010);
    step("stag_after", 1'b0, 3'b000, 3'b000);

    // Empty select stalls, then a real destination completes the beat.
    for (int i = 0; i < 5; i++) step("empty", 1'b1, 3'b000, 3'b111);
    step("empty_then", 1'b1, 3'b010, 3'b010);

    // Asynchronous reset in the middle of a beat.
    step("midrst_a", 1'b1, 3'b011, 3'b001);
    #2;
    rst_ni = 1'b0;
    #1;
    m_delivered = '0;
    m_locked    = '0;
    check("midrst.busy_o",  32'(busy_o),  32'h0);
    check("midrst.valid_o", 32'(valid_o), 32'h0);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    step("midrst_reoffer", 1'b1, 3'b011, 3'b000);
    step("midrst_done", 1'b1, 3'b011, 3'b011);

    // Destination mask changes mid-beat (locked or not, depending on the build).
    step("selchg_a", 1'b1, 3'b011, 3'b001);
    step("selchg_b", 1'b1, 3'b100, 3'b100);
    step("selchg_c", 1'b1, 3'b100, 3'b110);
    step("selchg_d", 1'b1, 3'b100, 3'b100);
    step("selchg_idle", 1'b0, 3'b000, 3'b000);

    // Random traffic obeying the source rules.
    cur_v = 1'b0;
    cur_s = '0;
    for (int i = 0; i < 400; i++) begin
      if (m_delivered != 0) begin
        v = 1'b1;
`ifdef STREAM_FORK_DYNAMIC_SEL_LOCK_EN
        s = 3'($urandom_range(0, 7));
`else
        s = cur_s;
`endif
      end else if (cur_v && !m_last_ready) begin
        v = 1'b1;
        s = 3'($urandom_range(0, 7));
      end else begin
        v = 1'($urandom_range(0, 1));
        s = 3'($urandom_range(0, 7));
      end
      step("rand", v, s, 3'($urandom_range(0, 7)));
      cur_v = v;
      cur_s = s;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
